// File: rtl/pampy_pkg.sv
// Shared definitions for the pampy datapath: stack opcode encoding and default widths.
// Imported by decode and by the operand stack.
package pampy_pkg;

  localparam int unsigned DataWDefault = 8;
  localparam int unsigned StkOpW       = 3;

  typedef enum logic [StkOpW-1:0] {
    OpNop   = 3'd0,
    OpPush  = 3'd1,
    OpPop   = 3'd2,
    OpBinop = 3'd3,
    OpDup   = 3'd4,
    OpRot2  = 3'd5
  } stk_op_e;

endpackage

// File: rtl/operand_stack_if.sv
// Operand stack command/status bundle. The master issues ops; the slave is the stack.
interface operand_stack_if
  import pampy_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDefault,
  parameter int unsigned DEPTH  = 16
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic [StkOpW-1:0] stk_op;
  logic [DATA_W-1:0] stk_data_in;
  logic [DATA_W-1:0] stk_tos;
  logic [DATA_W-1:0] stk_tos1;
  logic [CntW-1:0]   stk_count;
  logic              stk_empty;
  logic              stk_full;
  logic              stk_overflow;
  logic              stk_underflow;

  modport master (
    output stk_op,
    output stk_data_in,
    input  stk_tos,
    input  stk_tos1,
    input  stk_count,
    input  stk_empty,
    input  stk_full,
    input  stk_overflow,
    input  stk_underflow
  );

  modport slave (
    input  stk_op,
    input  stk_data_in,
    output stk_tos,
    output stk_tos1,
    output stk_count,
    output stk_empty,
    output stk_full,
    output stk_overflow,
    output stk_underflow
  );

endinterface

// File: rtl/stack_regfile.sv
// Stack storage: DEPTH x DATA_W, one synchronous write port, two asynchronous read ports.
// Contents are never reset; validity is tracked by the controller.
module stack_regfile #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  localparam int unsigned AddrW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AddrW-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AddrW-1:0]  rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [AddrW-1:0]  rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data_a = mem[rd_addr_a];
  assign rd_data_b = mem[rd_addr_b];

endmodule

// File: rtl/operand_stack.sv
// Operand stack with TOS/TOS1 cached in registers; deeper entries spill into stack_regfile.
// The regfile holds indices 0..count-3, so ROT2 and BINOP never need to write storage.
module operand_stack
  import pampy_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDefault,
  parameter int unsigned DEPTH  = 16
) (
  input  logic             general_clk,
  input  logic             general_reset,
  operand_stack_if.slave   stk
);

  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned CntW  = AddrW + 1;

  logic [CntW-1:0]   count_q, count_d;
  logic [DATA_W-1:0] tos_q, tos_d;
  logic [DATA_W-1:0] tos1_q, tos1_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic              rf_we;
  logic [AddrW-1:0]  rf_wr_addr;
  logic [AddrW-1:0]  rf_rd_addr;
  logic [DATA_W-1:0] rf_rd_data;
  logic [DATA_W-1:0] unused_rf_rd_data_b;
  logic [CntW-1:0]   count_m2;
  logic [CntW-1:0]   count_m3;
  logic              has1, has2, has3, is_full;
  logic [DATA_W-1:0] refill;

  assign count_m2   = count_q - CntW'(2);
  assign count_m3   = count_q - CntW'(3);
  assign rf_wr_addr = count_m2[AddrW-1:0];
  assign rf_rd_addr = count_m3[AddrW-1:0];

  assign has1    = (count_q != '0);
  assign has2    = (count_q >= CntW'(2));
  assign has3    = (count_q >= CntW'(3));
  assign is_full = (count_q == CntW'(DEPTH));

  // Third entry becomes the new TOS1 after POP/BINOP; absent entries read as zero.
  assign refill = has3 ? rf_rd_data : '0;

  stack_regfile #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_regfile (
    .clk       (general_clk),
    .we        (rf_we),
    .wr_addr   (rf_wr_addr),
    .wr_data   (tos1_q),
    .rd_addr_a (rf_rd_addr),
    .rd_data_a (rf_rd_data),
    .rd_addr_b (rf_rd_addr),
    .rd_data_b (unused_rf_rd_data_b)
  );

  always_comb begin
    count_d     = count_q;
    tos_d       = tos_q;
    tos1_d      = tos1_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    rf_we       = 1'b0;

    case (stk.stk_op)
      OpPush: begin
        if (is_full) begin
          overflow_d = 1'b1;
        end else begin
          rf_we   = has2;
          tos1_d  = tos_q;
          tos_d   = stk.stk_data_in;
          count_d = count_q + CntW'(1);
        end
      end
      OpPop: begin
        if (!has1) begin
          underflow_d = 1'b1;
        end else begin
          tos_d   = tos1_q;
          tos1_d  = refill;
          count_d = count_q - CntW'(1);
        end
      end
      OpBinop: begin
        if (!has2) begin
          underflow_d = 1'b1;
        end else begin
          tos_d   = stk.stk_data_in;
          tos1_d  = refill;
          count_d = count_q - CntW'(1);
        end
      end
      OpDup: begin
        if (!has1) begin
          underflow_d = 1'b1;
        end else if (is_full) begin
          overflow_d = 1'b1;
        end else begin
          rf_we   = has2;
          tos1_d  = tos_q;
          count_d = count_q + CntW'(1);
        end
      end
      OpRot2: begin
        if (!has2) begin
          underflow_d = 1'b1;
        end else begin
          tos_d  = tos1_q;
          tos1_d = tos_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge general_clk or posedge general_reset) begin
    if (general_reset) begin
      count_q     <= '0;
      tos_q       <= '0;
      tos1_q      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      tos_q       <= tos_d;
      tos1_q      <= tos1_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign stk.stk_tos       = tos_q;
  assign stk.stk_tos1      = tos1_q;
  assign stk.stk_count     = count_q;
  assign stk.stk_empty     = ~has1;
  assign stk.stk_full      = is_full;
  assign stk.stk_overflow  = overflow_q;
  assign stk.stk_underflow = underflow_q;

endmodule

// File: tb/tb_operand_stack.sv
// Directed bench for operand_stack with hand-computed expectations.
module tb_operand_stack;
  import pampy_pkg::*;

  logic general_clk;
  logic general_reset;
  int   n_cmp;
  int   n_err;

  operand_stack_if #(.DATA_W(8), .DEPTH(16)) stk ();

  operand_stack #(
    .DATA_W (8),
    .DEPTH  (16)
  ) dut (
    .general_clk   (general_clk),
    .general_reset (general_reset),
    .stk           (stk)
  );

  initial general_clk = 1'b0;
  always #5 general_clk = ~general_clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_op(input stk_op_e op, input logic [7:0] data);
    @(negedge general_clk);
    stk.stk_op      = op;
    stk.stk_data_in = data;
    @(posedge general_clk);
    #1;
    stk.stk_op = OpNop;
  endtask

  task automatic do_reset();
    @(negedge general_clk);
    stk.stk_op    = OpNop;
    general_reset = 1'b1;
    @(posedge general_clk);
    @(negedge general_clk);
    general_reset = 1'b0;
  endtask

  task automatic check_all(input string tag, input logic [7:0] tos, input logic [7:0] tos1,
                           input logic [4:0] cnt, input logic ovf, input logic unf);
    check_val({tag, ".tos"}, 32'(stk.stk_tos), 32'(tos));
    check_val({tag, ".tos1"}, 32'(stk.stk_tos1), 32'(tos1));
    check_val({tag, ".count"}, 32'(stk.stk_count), 32'(cnt));
    check_val({tag, ".empty"}, 32'(stk.stk_empty), 32'(cnt == 5'd0));
    check_val({tag, ".full"}, 32'(stk.stk_full), 32'(cnt == 5'd16));
    check_val({tag, ".ovf"}, 32'(stk.stk_overflow), 32'(ovf));
    check_val({tag, ".unf"}, 32'(stk.stk_underflow), 32'(unf));
  endtask

  initial begin
    n_cmp           = 0;
    n_err           = 0;
    general_reset   = 1'b1;
    stk.stk_op      = OpNop;
    stk.stk_data_in = 8'h00;

    // Ops presented while reset is held must be ignored.
    @(negedge general_clk);
    stk.stk_op      = OpPush;
    stk.stk_data_in = 8'hAA;
    @(posedge general_clk);
    #1;
    check_all("rst_hold", 8'h00, 8'h00, 5'd0, 1'b0, 1'b0);
    stk.stk_op = OpNop;
    @(negedge general_clk);
    general_reset = 1'b0;

    do_op(OpPush, 8'h11);
    check_all("push1", 8'h11, 8'h00, 5'd1, 1'b0, 1'b0);
    do_op(OpPush, 8'h22);
    do_op(OpPush, 8'h33);
    check_all("push3", 8'h33, 8'h22, 5'd3, 1'b0, 1'b0);
    do_op(OpRot2, 8'h00);
    check_all("rot2", 8'h22, 8'h33, 5'd3, 1'b0, 1'b0);
    do_op(OpBinop, 8'h55);
    check_all("binop", 8'h55, 8'h11, 5'd2, 1'b0, 1'b0);
    do_op(OpPop, 8'h00);
    check_all("pop_to1", 8'h11, 8'h00, 5'd1, 1'b0, 1'b0);
    do_op(OpRot2, 8'h00);
    check_all("rot2_one", 8'h11, 8'h00, 5'd1, 1'b0, 1'b1);
    do_op(stk_op_e'(3'd7), 8'hEE);
    check_all("reserved", 8'h11, 8'h00, 5'd1, 1'b0, 1'b1);

    do_reset();
    check_all("reset2", 8'h00, 8'h00, 5'd0, 1'b0, 1'b0);
    do_op(OpPop, 8'h00);
    check_all("pop_empty", 8'h00, 8'h00, 5'd0, 1'b0, 1'b1);
    do_op(OpPush, 8'h07);
    check_all("push_after_unf", 8'h07, 8'h00, 5'd1, 1'b0, 1'b1);

    do_reset();
    for (int i = 1; i <= 16; i++) begin
      do_op(OpPush, 8'(i));
    end
    check_all("fill", 8'h10, 8'h0F, 5'd16, 1'b0, 1'b0);
    do_op(OpPush, 8'hFF);
    check_all("push_full", 8'h10, 8'h0F, 5'd16, 1'b1, 1'b0);
    do_op(OpDup, 8'h00);
    check_all("dup_full", 8'h10, 8'h0F, 5'd16, 1'b1, 1'b0);
    // Drain to check every spilled entry comes back in order.
    for (int k = 1; k <= 15; k++) begin
      do_op(OpPop, 8'h00);
      check_val($sformatf("drain%0d.tos", k), 32'(stk.stk_tos), 32'(16 - k));
      check_val($sformatf("drain%0d.tos1", k), 32'(stk.stk_tos1), (k < 15) ? 32'(15 - k) : 32'd0);
    end
    check_all("drained", 8'h01, 8'h00, 5'd1, 1'b1, 1'b0);

    do_reset();
    do_op(OpDup, 8'h00);
    check_all("dup_empty", 8'h00, 8'h00, 5'd0, 1'b0, 1'b1);

    do_reset();
    do_op(OpPush, 8'h09);
    do_op(OpDup, 8'h00);
    check_all("dup", 8'h09, 8'h09, 5'd2, 1'b0, 1'b0);
    do_op(OpPop, 8'h00);
    do_op(OpBinop, 8'h44);
    check_all("binop_one", 8'h09, 8'h00, 5'd1, 1'b0, 1'b1);

    // Asynchronous reset between clock edges.
    do_reset();
    do_op(OpPush, 8'h01);
    do_op(OpPush, 8'h02);
    do_op(OpPush, 8'h03);
    #2;
    general_reset = 1'b1;
    #1;
    check_all("async_rst", 8'h00, 8'h00, 5'd0, 1'b0, 1'b0);
    @(negedge general_clk);
    general_reset = 1'b0;
    do_op(OpPush, 8'hA5);
    check_all("after_async", 8'hA5, 8'h00, 5'd1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
